// File: rtl/data_mem_mmio_pkg.sv
// data_mem_mmio_pkg: shared MMIO page, register offsets and STATUS bit layout
package data_mem_mmio_pkg;
  localparam logic [15:0] MMIO_PAGE_DEF = 16'hFFFF;
  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_TIMER = 4'h8;
  localparam int ST_FULL = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_OVF = 2;
  localparam int ST_COUNT = 4;
endpackage

// File: rtl/data_mem_mmio_tx_fifo.sv
// tx_fifo: synchronous FIFO; a push into a full FIFO is accepted only alongside a pop
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (do_push && !reset) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/data_mem_mmio.sv
// data_mem_mmio: word/byte RAM plus MMIO page with console TX FIFO and cycle timer
module data_mem_mmio
  import data_mem_mmio_pkg::*;
#(
  parameter int RAM_WORDS = 64,
  parameter int FIFO_DEPTH = 8,
  parameter logic [15:0] MMIO_PAGE = MMIO_PAGE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemByte,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  TxData,
  output logic        TxValid,
  input  logic        TxReady
);
  localparam int IW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [31:0] ram [RAM_WORDS];
  logic [IW-1:0] idx;
  logic [1:0] lane;
  logic [3:0] off;
  logic is_mmio, mmio_hit, push, pop, full, empty, ovf;
  logic [CW-1:0] count;
  logic [31:0] timer, rword, status;
  logic [7:0] rbyte;
  assign is_mmio = Addr[31:16] == MMIO_PAGE;
  assign mmio_hit = is_mmio && Addr[15:4] == '0;
  assign off = Addr[3:0];
  assign idx = Addr[2 +: IW];
  assign lane = Addr[1:0];
  assign push = MemWrite && mmio_hit && off == OFF_TXDATA;
  assign pop = TxValid && TxReady;
  assign TxValid = !empty;
  tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din(WriteData[7:0]),
    .pop(pop),
    .dout(TxData),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk)
    if (MemWrite && !is_mmio) begin
      if (MemByte) ram[idx][{lane, 3'b000} +: 8] <= WriteData[7:0];
      else ram[idx] <= WriteData;
    end
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
      ovf <= 1'b0;
    end else begin
      timer <= (MemWrite && mmio_hit && off == OFF_TIMER) ? WriteData : timer + 32'd1;
      if (push && full && !pop) ovf <= 1'b1;
      else if (MemWrite && mmio_hit && off == OFF_STATUS && WriteData[ST_OVF]) ovf <= 1'b0;
    end
  end
  always_comb begin
    status = '0;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_OVF] = ovf;
    status[ST_COUNT +: 4] = 4'(count);
    rword = ram[idx];
    rbyte = rword[{lane, 3'b000} +: 8];
    ReadData = !is_mmio ? (MemByte ? {24'b0, rbyte} : rword) :
               !mmio_hit ? 32'd0 :
               off == OFF_STATUS ? status :
               off == OFF_TIMER ? timer : 32'd0;
  end
endmodule
